id_ex_stage: RTL and testbench

ID/EX pipeline register for the 5-stage RV32 core, with integrated load-use hazard detection. It sits directly downstream of the IF/ID register and decode (Control, Registers, Sign_Extend) and upstream of ALU_Control/ALU/Data_Memory. It latches decoded control, operands and register indices each cycle. It inserts a one-cycle bubble on a load-use hazard and tells PC and IF/ID to hold. It also honours branch flush and a downstream stall, and counts inserted bubbles for performance debug.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/hazard_detect.sv | 34 +++
 rtl/id_ex_stage.sv | 118 +++++++++++
 tb/tb_id_ex_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32 pipeline: control-word layout, default
// datapath widths and a small helper used by hazard logic.
package cpu_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int FUNCT_W = 10;

    // Control word: {RegWrite, MemToReg, MemRead, MemWrite, ALUOp[1:0], ALUSrc}
    localparam int CTRL_W        = 7;
    localparam int CTRL_REGWRITE = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_ALUOP_HI = 2;
    localparam int CTRL_ALUOP_LO = 1;
    localparam int CTRL_ALUSRC   = 0;

    function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEMREAD];
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection (purely combinational).
// Flags when the instruction in EX is a valid load whose destination is a
// non-zero register that the valid instruction in ID actually reads.
// Ports:
//   ex_valid, ex_mem_read, ex_rd          - instruction currently in EX
//   id_valid, id_rs1, id_rs2,
//   id_rs1_used, id_rs2_used              - instruction currently in ID
//   load_use                              - 1 = ID must wait one cycle
module hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    output logic              load_use
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_rs1_used && (id_rs1 == ex_rd);
    assign rs2_match = id_rs2_used && (id_rs2 == ex_rd);

    // x0 is hard-wired zero, so a load targeting it never produces data
    // anyone waits on.
    assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid
                      && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
// Latches decoded control, operands and register indices each cycle; on a
// load-use hazard or branch flush it loads a bubble instead, and it holds
// everything while the core is disabled or EX/MEM asks for a stall.
// Ports:
//   clk_i, rst_i                 - clock, synchronous active-high reset
//   start_i, stall_i, flush_i    - core enable, downstream hold, squash ID
//   id_*                         - decoded instruction from the ID stage
//   ex_*                         - registered instruction presented to EX
//   hazard_stall_o               - combinational hold for PC and IF/ID
//   bubble_cnt_o                 - saturating count of inserted bubbles
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_AW = cpu_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                id_valid_i,
    input  logic [CTRL_W-1:0]   id_ctrl_i,
    input  logic [DATA_W-1:0]   id_rs1_data_i,
    input  logic [DATA_W-1:0]   id_rs2_data_i,
    input  logic [DATA_W-1:0]   id_imm_i,
    input  logic [FUNCT_W-1:0]  id_funct_i,
    input  logic [REG_AW-1:0]   id_rs1_i,
    input  logic [REG_AW-1:0]   id_rs2_i,
    input  logic [REG_AW-1:0]   id_rd_i,
    input  logic                id_rs1_used_i,
    input  logic                id_rs2_used_i,
    output logic                ex_valid_o,
    output logic [CTRL_W-1:0]   ex_ctrl_o,
    output logic [DATA_W-1:0]   ex_rs1_data_o,
    output logic [DATA_W-1:0]   ex_rs2_data_o,
    output logic [DATA_W-1:0]   ex_imm_o,
    output logic [FUNCT_W-1:0]  ex_funct_o,
    output logic [REG_AW-1:0]   ex_rs1_o,
    output logic [REG_AW-1:0]   ex_rs2_o,
    output logic [REG_AW-1:0]   ex_rd_o,
    output logic                hazard_stall_o,
    output logic [CNT_W-1:0]    bubble_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic load_use;
    logic hold;
    logic insert_bubble;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .ex_valid    (ex_valid_o),
        .ex_mem_read (ctrl_is_load(ex_ctrl_o)),
        .ex_rd       (ex_rd_o),
        .id_valid    (id_valid_i),
        .id_rs1      (id_rs1_i),
        .id_rs2      (id_rs2_i),
        .id_rs1_used (id_rs1_used_i),
        .id_rs2_used (id_rs2_used_i),
        .load_use    (load_use)
    );

    assign hold          = stall_i || !start_i;
    assign insert_bubble = flush_i || load_use;

    // A flush redirects fetch, so the load-use hold must not block it; the
    // squashed instruction is replaced by the bubble anyway.
    assign hazard_stall_o = hold || (load_use && !flush_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid_o    <= 1'b0;
            ex_ctrl_o     <= '0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_imm_o      <= '0;
            ex_funct_o    <= '0;
            ex_rs1_o      <= '0;
            ex_rs2_o      <= '0;
            ex_rd_o       <= '0;
            bubble_cnt_o  <= '0;
        end else if (hold) begin
            // every register, including the counter, keeps its value
        end else if (insert_bubble) begin
            ex_valid_o    <= 1'b0;
            ex_ctrl_o     <= '0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_imm_o      <= '0;
            ex_funct_o    <= '0;
            ex_rs1_o      <= '0;
            ex_rs2_o      <= '0;
            ex_rd_o       <= '0;
            if (bubble_cnt_o != CNT_MAX) begin
                bubble_cnt_o <= bubble_cnt_o + CNT_ONE;
            end
        end else begin
            // An invalid ID slot still moves its data along; only valid and
            // control are cleared so nothing downstream has side effects.
            ex_valid_o    <= id_valid_i;
            ex_ctrl_o     <= id_valid_i ? id_ctrl_i : '0;
            ex_rs1_data_o <= id_rs1_data_i;
            ex_rs2_data_o <= id_rs2_data_i;
            ex_imm_o      <= id_imm_i;
            ex_funct_o    <= id_funct_i;
            ex_rs1_o      <= id_rs1_i;
            ex_rs2_o      <= id_rs2_i;
            ex_rd_o       <= id_rd_i;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int CW = 4;

    localparam logic [6:0] C_LW   = 7'b1110001;
    localparam logic [6:0] C_RTYP = 7'b1000100;
    localparam logic [6:0] C_ADDI = 7'b1000101;
    localparam logic [6:0] C_SW   = 7'b0001001;

    localparam int M_LOAD   = 0;
    localparam int M_BUBBLE = 1;
    localparam int M_HOLD   = 2;

    typedef struct packed {
        logic        valid;
        logic [6:0]  ctrl;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [9:0]  funct;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        u1;
        logic        u2;
    } instr_t;

    typedef struct packed {
        logic        valid;
        logic [6:0]  ctrl;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [9:0]  funct;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } st_t;

    typedef struct packed {
        int          id;
        st_t         st;
        logic [CW-1:0] cnt;
    } st_e;

    typedef struct packed {
        int   id;
        logic hz;
    } hz_e;

    logic          clk = 1'b0;
    logic          rst, start, stall, flush;
    logic          id_valid;
    logic [6:0]    id_ctrl;
    logic [31:0]   id_rs1_data, id_rs2_data, id_imm;
    logic [9:0]    id_funct;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic          id_rs1_used, id_rs2_used;
    logic          ex_valid;
    logic [6:0]    ex_ctrl;
    logic [31:0]   ex_rs1_data, ex_rs2_data, ex_imm;
    logic [9:0]    ex_funct;
    logic [4:0]    ex_rs1, ex_rs2, ex_rd;
    logic          hazard_stall;
    logic [CW-1:0] bubble_cnt;

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;
    st_e st_q[$];
    hz_e hz_q[$];
    st_t cur;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(CW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .stall_i        (stall),
        .flush_i        (flush),
        .id_valid_i     (id_valid),
        .id_ctrl_i      (id_ctrl),
        .id_rs1_data_i  (id_rs1_data),
        .id_rs2_data_i  (id_rs2_data),
        .id_imm_i       (id_imm),
        .id_funct_i     (id_funct),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_rd_i        (id_rd),
        .id_rs1_used_i  (id_rs1_used),
        .id_rs2_used_i  (id_rs2_used),
        .ex_valid_o     (ex_valid),
        .ex_ctrl_o      (ex_ctrl),
        .ex_rs1_data_o  (ex_rs1_data),
        .ex_rs2_data_o  (ex_rs2_data),
        .ex_imm_o       (ex_imm),
        .ex_funct_o     (ex_funct),
        .ex_rs1_o       (ex_rs1),
        .ex_rs2_o       (ex_rs2),
        .ex_rd_o        (ex_rd),
        .hazard_stall_o (hazard_stall),
        .bubble_cnt_o   (bubble_cnt)
    );

    function automatic instr_t mk(input logic v, input logic [6:0] c,
                                  input logic [4:0] r1, input logic [4:0] r2,
                                  input logic [4:0] d, input logic u1,
                                  input logic u2, input logic [31:0] seed);
        instr_t i;
        i.valid = v;
        i.ctrl  = c;
        i.rs1d  = seed;
        i.rs2d  = ~seed;
        i.imm   = seed ^ 32'h5a5a_a5a5;
        i.funct = seed[9:0] ^ 10'h2b3;
        i.rs1   = r1;
        i.rs2   = r2;
        i.rd    = d;
        i.u1    = u1;
        i.u2    = u2;
        return i;
    endfunction

    function automatic instr_t rnd_instr();
        return mk(1'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), 1'($urandom), 1'($urandom), $urandom);
    endfunction

    task automatic step(input instr_t ins, input logic r, input logic en,
                        input logic stl, input logic fl, input int mode,
                        input logic [CW-1:0] cnt, input logic chk_hz,
                        input logic hz);
        st_e e;
        hz_e h;
        @(negedge clk);
        step_no++;
        rst = r; start = en; stall = stl; flush = fl;
        id_valid = ins.valid; id_ctrl = ins.ctrl;
        id_rs1_data = ins.rs1d; id_rs2_data = ins.rs2d; id_imm = ins.imm;
        id_funct = ins.funct; id_rs1 = ins.rs1; id_rs2 = ins.rs2; id_rd = ins.rd;
        id_rs1_used = ins.u1; id_rs2_used = ins.u2;
        if (mode == M_BUBBLE) begin
            cur = '0;
        end else if (mode == M_LOAD) begin
            cur.valid = ins.valid;
            cur.ctrl  = ins.valid ? ins.ctrl : 7'd0;
            cur.rs1d  = ins.rs1d;
            cur.rs2d  = ins.rs2d;
            cur.imm   = ins.imm;
            cur.funct = ins.funct;
            cur.rs1   = ins.rs1;
            cur.rs2   = ins.rs2;
            cur.rd    = ins.rd;
        end
        e.id = step_no; e.st = cur; e.cnt = cnt;
        st_q.push_back(e);
        if (chk_hz) begin
            h.id = step_no; h.hz = hz;
            hz_q.push_back(h);
        end
    endtask

    // Combinational stall is checked mid-cycle, after inputs settle.
    initial begin
        hz_e h;
        forever begin
            @(negedge clk);
            #2;
            if (hz_q.size() > 0) begin
                h = hz_q.pop_front();
                checks++;
                if (hazard_stall !== h.hz) begin
                    failures++;
                    $display("FAIL hazard_stall step=%0d got=%b exp=%b", h.id, hazard_stall, h.hz);
                end
            end
        end
    end

    // Registered state is checked just after each rising edge.
    initial begin
        st_e e;
        st_t got;
        forever begin
            @(posedge clk);
            #1;
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                got = {ex_valid, ex_ctrl, ex_rs1_data, ex_rs2_data, ex_imm,
                       ex_funct, ex_rs1, ex_rs2, ex_rd};
                checks++;
                if (got !== e.st) begin
                    failures++;
                    $display("FAIL ex_fields step=%0d got=%h exp=%h", e.id, got, e.st);
                end
                checks++;
                if (bubble_cnt !== e.cnt) begin
                    failures++;
                    $display("FAIL bubble_cnt step=%0d got=%0d exp=%0d", e.id, bubble_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        instr_t lw5, add_use5, lw0, add_x0, addi_r2f, lw9, sw9, nohz, other;
        instr_t i;
        logic [CW-1:0] c;
        cur = '0;
        rst = 1'b1; start = 1'b1; stall = 1'b0; flush = 1'b0;
        id_valid = 1'b0; id_ctrl = '0; id_rs1_data = '0; id_rs2_data = '0;
        id_imm = '0; id_funct = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;

        lw5      = mk(1'b1, C_LW,   5'd2, 5'd0, 5'd5,  1'b1, 1'b0, 32'h0000_0040);
        add_use5 = mk(1'b1, C_RTYP, 5'd5, 5'd7, 5'd6,  1'b1, 1'b1, 32'h1234_5678);
        lw0      = mk(1'b1, C_LW,   5'd3, 5'd0, 5'd0,  1'b1, 1'b0, 32'h0000_0080);
        add_x0   = mk(1'b1, C_RTYP, 5'd0, 5'd0, 5'd1,  1'b1, 1'b1, 32'hcafe_f00d);
        addi_r2f = mk(1'b1, C_ADDI, 5'd1, 5'd5, 5'd6,  1'b1, 1'b0, 32'h0000_0005);
        lw9      = mk(1'b1, C_LW,   5'd4, 5'd0, 5'd9,  1'b1, 1'b0, 32'h0000_0100);
        sw9      = mk(1'b1, C_SW,   5'd8, 5'd9, 5'd0,  1'b1, 1'b1, 32'hdead_beef);
        nohz     = mk(1'b1, C_RTYP, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 32'h0bad_cafe);
        other    = mk(1'b1, C_RTYP, 5'd3, 5'd4, 5'd11, 1'b1, 1'b1, 32'h7777_1111);

        // reset with random decode inputs
        step(rnd_instr(), 1, 1, 0, 0, M_BUBBLE, 0, 0, 0);
        step(rnd_instr(), 1, 1, 0, 0, M_BUBBLE, 0, 1, 0);
        // load-use: one bubble, then the dependent add enters EX
        step(lw5,      0, 1, 0, 0, M_LOAD,   0, 1, 0);
        step(add_use5, 0, 1, 0, 0, M_BUBBLE, 1, 1, 1);
        step(add_use5, 0, 1, 0, 0, M_LOAD,   1, 1, 0);
        // x0 destination never stalls
        step(lw0,      0, 1, 0, 0, M_LOAD,   1, 1, 0);
        step(add_x0,   0, 1, 0, 0, M_LOAD,   1, 1, 0);
        // rs2 field matches but is unused
        step(lw5,      0, 1, 0, 0, M_LOAD,   1, 1, 0);
        step(addi_r2f, 0, 1, 0, 0, M_LOAD,   1, 1, 0);
        // flush beats load-use
        step(lw5,      0, 1, 0, 0, M_LOAD,   1, 1, 0);
        step(add_use5, 0, 1, 0, 1, M_BUBBLE, 2, 1, 0);
        // store data operand counts as a use
        step(lw9,      0, 1, 0, 0, M_LOAD,   2, 1, 0);
        step(sw9,      0, 1, 0, 0, M_BUBBLE, 3, 1, 1);
        step(sw9,      0, 1, 0, 0, M_LOAD,   3, 1, 0);
        // downstream stall over a pending load-use, then release
        step(lw5,      0, 1, 0, 0, M_LOAD,   3, 1, 0);
        step(add_use5, 0, 1, 1, 0, M_HOLD,   3, 1, 1);
        step(other,    0, 1, 1, 0, M_HOLD,   3, 1, 1);
        step(sw9,      0, 1, 1, 0, M_HOLD,   3, 1, 1);
        step(nohz,     0, 1, 0, 0, M_LOAD,   3, 1, 0);
        // core disabled holds
        step(other,    0, 0, 0, 0, M_HOLD,   3, 1, 1);
        // invalid ID slot: data moves, valid/ctrl cleared
        i = other; i.valid = 1'b0;
        step(i,        0, 1, 0, 0, M_LOAD,   3, 1, 0);
        // reset during a stall, then no residual stall
        step(other,    1, 1, 1, 0, M_BUBBLE, 0, 1, 1);
        step(nohz,     0, 1, 0, 0, M_LOAD,   0, 1, 0);
        // reset during a load-use
        step(lw5,      0, 1, 0, 0, M_LOAD,   0, 1, 0);
        step(add_use5, 1, 1, 0, 0, M_BUBBLE, 0, 1, 1);
        // saturation of the bubble counter
        for (int k = 0; k < 20; k++) begin
            c = (k + 1 > 15) ? 4'd15 : 4'(k + 1);
            step(other, 0, 1, 0, 1, M_BUBBLE, c, 1, 0);
        end
        step(nohz,     0, 1, 0, 0, M_LOAD,  15, 1, 0);

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (st_q.size() != 0 || hz_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d/%0d exp=0/0", st_q.size(), hz_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
